// File: rtl/prog_imem_pkg.sv
// Shared types and defaults for the writable MIPS program memory.
package prog_imem_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} prog_imem_state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_DEPTH  = 4096;

endpackage

// File: rtl/imem_bank.sv
// Single-port synchronous RAM with registered read; one access per cycle.
module imem_bank #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/prog_imem.sv
// Loadable instruction store: valid/ready load port, registered fetch port.
// Optional word parity enabled by defining PROG_IMEM_PARITY_EN.
module prog_imem
    import prog_imem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BYTE_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
`ifdef PROG_IMEM_PARITY_EN
    output logic              instr_perr,
`endif
    output logic              running,
    output logic [ADDR_W:0]   prog_len
);

`ifdef PROG_IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    prog_imem_state_t  state_q, state_d;
    logic [ADDR_W:0]   count_q, count_nxt, prog_len_q;
    logic              accept, fetch_ok, rd_en, oor, hi_nz;
    logic [31:0]       word_addr;
    logic [ADDR_W-1:0] idx, bank_addr;
    logic              rd_pend_q, instr_valid_q, addr_err_q;
    logic [DATA_W-1:0] instr_hold_q;
    logic [MEM_W-1:0]  bank_wdata, bank_rdata;

    assign word_addr = (BYTE_ADDR != 0) ? {2'b00, fetch_addr[31:2]} : fetch_addr;
    assign idx       = word_addr[ADDR_W-1:0];
    assign hi_nz     = (word_addr >> ADDR_W) != 32'd0;
    assign oor       = hi_nz || ({1'b0, idx} >= prog_len_q);
    assign count_nxt = count_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        accept     = 1'b0;
        fetch_ok   = 1'b0;
        unique case (state_q)
            IDLE: if (load_start) state_d = LOAD;
            LOAD: begin
                load_ready = (count_q < DEPTH_C);
                // a restart wins over a beat presented in the same cycle
                if (!load_start && load_valid && load_ready) begin
                    accept = 1'b1;
                    if (load_last || count_nxt == DEPTH_C) state_d = RUN;
                end
            end
            RUN: begin
                if (load_start) state_d  = LOAD;
                else            fetch_ok = fetch_en;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            prog_len_q <= '0;
        end else begin
            if (load_start)  count_q <= '0;
            else if (accept) count_q <= count_nxt;
            if (accept && state_d == RUN) prog_len_q <= count_nxt;
        end
    end

    // out-of-range fetches never touch the bank; they return NOP from the hold register
    assign rd_en     = fetch_ok && !oor;
    assign bank_addr = accept ? count_q[ADDR_W-1:0] : idx;

`ifdef PROG_IMEM_PARITY_EN
    assign bank_wdata = {^load_data, load_data};
    assign instr_perr = rd_pend_q && (^bank_rdata);
`else
    assign bank_wdata = load_data;
`endif

    imem_bank #(.WIDTH(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .en    (accept || rd_en),
        .we    (accept),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            instr_hold_q  <= '0;
        end else begin
            if (rd_pend_q) instr_hold_q <= bank_rdata[DATA_W-1:0];
            rd_pend_q     <= rd_en;
            instr_valid_q <= fetch_ok;
            if (fetch_ok) begin
                addr_err_q <= oor;
                if (oor) instr_hold_q <= DATA_W'(NOP_WORD);
            end
        end
    end

    assign instr       = rd_pend_q ? bank_rdata[DATA_W-1:0] : instr_hold_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign running     = (state_q == RUN);
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_prog_imem.sv
// Randomized self-checking bench for prog_imem (DEPTH=8, byte addressing).
module tb_prog_imem;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] instr;
    logic        instr_valid, addr_err, running;
    logic [3:0]  prog_len;
`ifdef PROG_IMEM_PARITY_EN
    logic        instr_perr;
`endif

    int n_chk = 0, n_err = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          mdl_len = 0;
    logic [31:0] exp_instr = '0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    prog_imem #(.DATA_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
`ifdef PROG_IMEM_PARITY_EN
        .instr_perr  (instr_perr),
`endif
        .running     (running),
        .prog_len    (prog_len)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] words[$], input bit use_last);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("ready_after_start", 32'(load_ready), 32'd1);
        for (int i = 0; i < words.size(); i++) begin
            while ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                step();
            end
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = use_last && (i == words.size() - 1);
            chk("load_ready", 32'(load_ready), 32'd1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("running_after_load", 32'(running), 32'd1);
        chk("prog_len", 32'(prog_len), 32'(words.size()));
        for (int i = 0; i < words.size(); i++) mdl_mem[i] = words[i];
        mdl_len = words.size();
    endtask

    // reference: a byte PC addresses word pc/4; valid only below the loaded length
    task automatic do_fetch(input logic [31:0] pc, input bit fe);
        fetch_en   = fe;
        fetch_addr = pc;
        step();
        fetch_en = 1'b0;
        if (fe) begin
            if ((pc / 4) < mdl_len) begin
                exp_instr = mdl_mem[pc / 4];
                exp_err   = 1'b0;
            end else begin
                exp_instr = 32'h0;
                exp_err   = 1'b1;
            end
        end
        chk("instr_valid", 32'(instr_valid), 32'(fe));
        chk("instr", instr, exp_instr);
        chk("addr_err", 32'(addr_err), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        int          len, w;
        logic [31:0] pc;

        // reset state
        step();
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        rst = 1'b1;
        step();

        // IDLE ignores fetches and load beats
        fetch_en = 1'b1;
        load_valid = 1'b1;
        load_data = 32'h1111_1111;
        chk("idle_load_ready", 32'(load_ready), 32'd0);
        step();
        fetch_en = 1'b0;
        load_valid = 1'b0;
        chk("idle_instr_valid", 32'(instr_valid), 32'd0);
        chk("idle_instr", instr, 32'd0);

        // directed program and fetches
        q = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0000_0000};
        do_load(q, 1'b1);
        do_fetch(32'h8, 1'b1);
        do_fetch(32'h10, 1'b1);
        do_fetch(32'h0, 1'b1);
        do_fetch(32'h4, 1'b0);
        do_fetch(32'h8000_0000, 1'b1);
        do_fetch(32'h7, 1'b1);

        // load_start in RUN drops the simultaneous fetch
        fetch_en = 1'b1;
        fetch_addr = 32'h0;
        load_start = 1'b1;
        step();
        fetch_en = 1'b0;
        load_start = 1'b0;
        chk("restart_instr_valid", 32'(instr_valid), 32'd0);
        chk("restart_running", 32'(running), 32'd0);
        chk("restart_load_ready", 32'(load_ready), 32'd1);

        // full-depth load without load_last auto-enters RUN
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
        do_load(q, 1'b0);
        load_valid = 1'b1;
        load_data = 32'hFFFF_FFFF;
        chk("full_load_ready", 32'(load_ready), 32'd0);
        step();
        load_valid = 1'b0;
        chk("full_prog_len", 32'(prog_len), 32'd8);
        do_fetch(32'h1C, 1'b1);
        do_fetch(32'h0, 1'b1);
        do_fetch(32'h20, 1'b1);

        // restart mid-load; the beat in the restart cycle is dropped
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data = 32'hA000_0000 + 32'(i);
            step();
        end
        load_start = 1'b1;
        load_data = 32'h5555_5555;
        step();
        load_start = 1'b0;
        chk("midrestart_ready", 32'(load_ready), 32'd1);
        chk("midrestart_running", 32'(running), 32'd0);
        load_data = 32'hDEAD_BEEF;
        load_last = 1'b1;
        step();
        load_valid = 1'b0;
        load_last = 1'b0;
        chk("midrestart_running2", 32'(running), 32'd1);
        chk("midrestart_prog_len", 32'(prog_len), 32'd1);
        mdl_mem[0] = 32'hDEAD_BEEF;
        mdl_len = 1;
        do_fetch(32'h0, 1'b1);
        do_fetch(32'h4, 1'b1);

        // asynchronous reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 32'h1234_0000;
        step();
        rst = 1'b0;
        #1;
        chk("midreset_prog_len", 32'(prog_len), 32'd0);
        chk("midreset_running", 32'(running), 32'd0);
        chk("midreset_ready", 32'(load_ready), 32'd0);
        chk("midreset_instr", instr, 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("postreset_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        mdl_len = 0;
        exp_instr = 32'h0;
        exp_err = 1'b0;

        // randomized programs and fetch streams
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, DEPTH);
            q = {};
            for (int i = 0; i < len; i++) q.push_back($urandom);
            do_load(q, (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
            for (int f = 0; f < 12; f++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        w = $urandom_range(0, len - 1);
                        pc = 32'(w * 4) + 32'($urandom_range(0, 3));
                    end
                    1: begin
                        w = $urandom_range(len, DEPTH + 2);
                        pc = 32'(w * 4);
                    end
                    default: pc = $urandom;
                endcase
                do_fetch(pc, $urandom_range(0, 4) != 0);
            end
        end

`ifdef PROG_IMEM_PARITY_EN
        q = '{32'h1234_5678};
        do_load(q, 1'b1);
        do_fetch(32'h0, 1'b1);
        chk("perr_clean", 32'(instr_perr), 32'd0);
        dut.u_bank.mem[0] = dut.u_bank.mem[0] ^ 33'h10;
        mdl_mem[0] = 32'h1234_5668;
        do_fetch(32'h0, 1'b1);
        chk("perr_flip", 32'(instr_perr), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prog_imem.md
Name: prog_imem

Overview:
Parametrised program memory for the MIPS core. It replaces the fixed 4096x32 instruction ROM with a writable instruction store. A load port streams a program in through a valid/ready handshake, and a fetch port serves the core's PC with one-cycle registered latency. A small FSM gates the two ports so that loading and fetching never overlap. The block sits between the top level and the core, and its fetch address is driven directly by pc.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 4096, number of words; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), word-index width; derived, do not override.
- BYTE_ADDR, 1. When 1, fetch_addr is a byte address: bits [1:0] are ignored and the word index is fetch_addr[ADDR_W+1:2]. When 0, fetch_addr is a word index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that (re)starts a program load.
- load_valid  in  1  a load beat is present.
- load_data  in  DATA_W  load beat payload.
- load_last  in  1  qualifies the final beat of the program.
- load_ready  out  1  the block accepts a beat this cycle.
- fetch_en  in  1  fetch request.
- fetch_addr  in  32  PC.
- instr  out  DATA_W  fetched word.
- instr_valid  out  1  instr is updated this cycle.
- addr_err  out  1  the last fetch was out of range.
- running  out  1  the FSM is in RUN.
- prog_len  out  ADDR_W+1  number of words loaded.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE, load count=0, prog_len=0.
  - instr=0, instr_valid=0, addr_err=0, load_ready=0, running=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - load_start -> LOAD, count=0.
  - fetch_en is ignored: instr_valid=0 and instr holds.
  - load_valid is ignored: load_ready=0.
- LOAD:
  - load_ready = (count < DEPTH), combinational from state and count.
  - A beat is accepted when load_valid & load_ready. The beat writes mem[count]=load_data and increments count.
  - If the accepted beat has load_last=1, or the increment brings count to DEPTH: the next state is RUN and prog_len takes the new count.
  - load_start while in LOAD restarts the load: count=0, and any beat in that same cycle is dropped.
  - Fetches are ignored.
- RUN:
  - running=1, load_ready=0.
  - A fetch with fetch_en=1 at cycle N gives instr=mem[idx] and instr_valid=1 at cycle N+1.
  - If fetch_en=0, instr_valid=0 next cycle and instr holds.
- Out of range:
  - Out of range means any fetch_addr bits above the index field are non-zero, or idx >= prog_len.
  - Response: instr=0 (NOP), instr_valid=1, addr_err=1, all registered with the fetch. addr_err clears on the next in-range fetch.
- load_start in RUN:
  - Next state is LOAD, count=0, running drops the next cycle.
  - A fetch in that same cycle is dropped: instr_valid=0.
- Simultaneous load_start and load_valid in IDLE: only the start takes effect.
- Single-port memory: one read or one write per cycle, never both, which the FSM guarantees.
- Reset mid-load: the partial program is abandoned, prog_len=0, and a fresh load_start is required.

Optional Feature:
- Macro name: PROG_IMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed over load_data at write time.
  - A fetch recomputes parity. On a mismatch it raises output instr_perr (1 bit, registered together with instr_valid) for that cycle.
  - instr is still delivered unmodified.
- When not defined: no parity storage and no instr_perr port.

Decomposition:
- Shared package prog_imem_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, RUN} prog_imem_state_t.
  - localparam NOP_WORD = 32'h0000_0000.
  - Default values for DATA_W and DEPTH.
- Sub-module imem_bank: single-port synchronous RAM of DEPTH x (DATA_W [+1]) with registered read. It is kept inferable, and the FSM and handshake stay in prog_imem.

Test Plan:
1. Reset, then load_start, then 4 beats (0x20080005, 0x20090003, 0x01095020, 0x00000000) with load_last on beat 4.
   - load_ready=1 throughout.
   - running=1 the cycle after beat 4; prog_len=4.
   - Fetch pc=0x8 -> instr=0x01095020 and instr_valid=1 one cycle later.
2. Fetch pc=0x10 with prog_len=4 -> instr=0, addr_err=1. The next fetch at pc=0x0 -> addr_err=0, instr=0x20080005.
3. DEPTH=8 build, 8 beats with no load_last:
   - Auto-transition to RUN.
   - load_ready=0 after beat 8; a 9th load_valid is not accepted.
   - prog_len=8.
4. Mid-load after 2 beats, assert load_start while load_valid=1:
   - The beat is dropped and count=0.
   - Reload 1 beat (0xDEADBEEF, last) -> prog_len=1 and fetch pc=0 returns 0xDEADBEEF.
5. In RUN, fetch_en=1 and load_start in the same cycle -> instr_valid=0 next cycle, running=0, load_ready=1.
6. With PROG_IMEM_PARITY_EN, force a stored bit flip through the bench backdoor on word 0 -> fetch pc=0 gives instr_perr=1 and instr equal to the stored value.
